idu_inst_queue: RTL and testbench
=================================

// Module: idu_inst_queue
// PURPOSE
//  Instruction queue between the fetch stage and the decoder. It decouples the two stages.
//  - Accepts {inst, inst_addr, int_flag} triples from fetch with a valid/ready handshake.
//  - Buffers up to DEPTH entries and presents the oldest entry to decode in order.
//  - Flushes all contents on a control-flow redirect (jump) from the control unit.
//  - Stalls its output while the control unit holds the decode stage.
// PARAMETERS
//  DEPTH      4   number of entries; power of 2, >=2
//  AW         32  instruction address width (= `INST_ADDR_WIDTH)
//  DW         32  instruction data width (= `INST_DATA_WIDTH)
//  IW         8   interrupt flag width (= width of `INT_BUS)
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rst          in   1              asynchronous, active-high reset
//  flush_i      in   1              jump_flag from control; discard all entries
//  hold_i       in   1              decode hold from control; block dequeue
//  valid_i      in   1              fetch presents an entry
//  inst_i       in   DW             instruction word
//  inst_addr_i  in   AW             instruction address
//  int_flag_i   in   IW             interrupt flags tagged to this instruction
//  ready_o      out  1              queue can accept (not full)
//  valid_o      out  1              head entry available to decode
//  inst_o       out  DW             head instruction; `INST_NOP when valid_o=0
//  inst_addr_o  out  AW             head address; 0 when valid_o=0
//  int_flag_o   out  IW             head int flags; 0 when valid_o=0
//  ready_i      in   1              decode consumes head this cycle
//  count_o      out  clog2(DEPTH)+1 current occupancy
// BEHAVIOUR
//  - Reset (async assert, sync release): rd_ptr=wr_ptr=0, count=0.
//    Outputs after reset: ready_o=1, valid_o=0, inst_o=`INST_NOP, inst_addr_o=0, int_flag_o=0, count_o=0.
//  - Pointers are clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//    empty = (rd==wr); full = index bits equal and wrap bits differ. Wrap at DEPTH-1 -> 0 is natural overflow.
//  - push = valid_i & ready_o & ~flush_i. The entry is written at wr_ptr index and wr_ptr increments.
//  - pop  = valid_o & ready_i. rd_ptr increments.
//  - ready_o = ~full. This is combinational from registered pointers only and has no dependence on ready_i.
//    When full, no push is accepted even if a pop happens in the same cycle (no pass-through).
//  - valid_o = ~empty & ~hold_i & ~flush_i. Head fields are muxed from storage at rd_ptr index.
//    They are forced to NOP/0/0 when valid_o=0.
//  - Latency: a push at edge N is visible on valid_o in cycle N+1. There is no same-cycle bypass.
//  - Simultaneous push and pop (not full, not empty): both occur and count is unchanged.
//  - Push into empty with ready_i=1: no pop that cycle, because valid_o=0.
//  - flush_i=1: at the next edge rd_ptr=wr_ptr=0 and count=0.
//    The push and pop of that cycle are both suppressed. valid_o=0 during the flush cycle.
//    flush_i has priority over everything except rst.
//  - hold_i=1: no pop. Pushes continue until full. Contents are preserved.
//  - count_o = wr_ptr - rd_ptr (modular, full width). Invariant: 0 <= count_o <= DEPTH.
//  - Storage arrays are not reset. Only pointers are reset, so read-before-write X cannot reach outputs (masked by valid_o).
//  - Reset asserted mid-operation: all entries are dropped immediately. Outputs return to reset values asynchronously.
// STRUCTURE
//  - Shared defines: `INST_NOP (32'h00000013), `INST_ADDR_WIDTH, `INST_DATA_WIDTH, `INT_BUS, `ZeroWord.
//    DEPTH is a local parameter default, not a global define.
//  - One sub-module: idu_iq_ptr, which holds the rd/wr pointer pair and the full/empty/count logic,
//    with flush and async reset.
//    The top level owns the three storage arrays (inst, addr, int_flag) and the output NOP masking.
// TESTING
//  1 Reset then idle: rst pulse, valid_i=0 -> ready_o=1, valid_o=0, inst_o=32'h13, count_o=0.
//  2 Fill: push addr 0x0,0x4,0x8,0xC with ready_i=0.
//    -> count_o 1..4; ready_o=0 after 4th push; a 5th push (0x10) is not accepted.
//  3 Drain with wrap: from full, ready_i=1 while pushing 0x10,0x14.
//    -> outputs 0x0,0x4,... in order; count_o stays 4 then 3 during the simultaneous-push phase.
//  4 Flush mid-stream: 3 entries queued; flush_i=1 with valid_i=1 (addr 0x20).
//    -> valid_o=0 same cycle; next cycle count_o=0 and 0x20 is not stored.
//  5 Hold: 2 entries queued, hold_i=1 for 3 cycles with ready_i=1.
//    -> valid_o=0, no pop, count_o stays 2. Release -> head is the oldest entry.
//  6 Int tag: push inst 0x00100093 with int_flag_i=8'h01 -> appears with int_flag_o=8'h01 exactly with that inst.

Source files
------------

// File: rtl/idu_inst_queue_pkg.sv
// Shared widths, constants and entry payload type for the decode-side instruction queue.
package idu_inst_queue_pkg;

    localparam int unsigned INST_ADDR_WIDTH  = 32;
    localparam int unsigned INST_DATA_WIDTH  = 32;
    localparam int unsigned INT_BUS_WIDTH    = 8;
    localparam int unsigned IQ_DEPTH_DEFAULT = 4;

    localparam logic [INST_DATA_WIDTH-1:0] INST_NOP  = 32'h0000_0013;
    localparam logic [INST_DATA_WIDTH-1:0] ZERO_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [INST_DATA_WIDTH-1:0] inst;
        logic [INST_ADDR_WIDTH-1:0] addr;
        logic [INT_BUS_WIDTH-1:0]   int_flag;
    } iq_entry_t;

endpackage

// File: rtl/idu_iq_ptr.sv
// Read/write pointer pair with wrap bit; derives full, empty and occupancy.
module idu_iq_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    output logic [IDXW-1:0] wr_idx_o,
    output logic [IDXW-1:0] rd_idx_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [IDXW:0]   count_o
);

    logic [IDXW:0] r_wr_ptr;
    logic [IDXW:0] r_rd_ptr;

    // Flush rewinds both pointers to zero, overriding any push/pop this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + (IDXW+1)'(1);
            if (pop_i)  r_rd_ptr <= r_rd_ptr + (IDXW+1)'(1);
        end
    end

    assign wr_idx_o = r_wr_ptr[IDXW-1:0];
    assign rd_idx_o = r_rd_ptr[IDXW-1:0];
    assign empty_o  = (r_wr_ptr == r_rd_ptr);
    assign full_o   = (r_wr_ptr[IDXW-1:0] == r_rd_ptr[IDXW-1:0]) &&
                      (r_wr_ptr[IDXW] != r_rd_ptr[IDXW]);
    assign count_o  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/idu_inst_queue.sv
// Fetch-to-decode instruction queue: in-order buffer with flush on redirect and decode hold.
module idu_inst_queue
    import idu_inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT,
    parameter int unsigned AW    = INST_ADDR_WIDTH,
    parameter int unsigned DW    = INST_DATA_WIDTH,
    parameter int unsigned IW    = INT_BUS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   hold_i,
    input  logic                   valid_i,
    input  logic [DW-1:0]          inst_i,
    input  logic [AW-1:0]          inst_addr_i,
    input  logic [IW-1:0]          int_flag_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [DW-1:0]          inst_o,
    output logic [AW-1:0]          inst_addr_o,
    output logic [IW-1:0]          int_flag_o,
    input  logic                   ready_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned IDXW = $clog2(DEPTH);

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [IDXW-1:0] w_wr_idx;
    logic [IDXW-1:0] w_rd_idx;

    logic [DW-1:0] r_inst     [DEPTH];
    logic [AW-1:0] r_addr     [DEPTH];
    logic [IW-1:0] r_int_flag [DEPTH];

    // No pass-through when full: ready_o depends only on the registered pointers.
    assign ready_o = ~w_full;
    assign valid_o = ~w_empty & ~hold_i & ~flush_i;
    assign w_push  = valid_i & ready_o & ~flush_i;
    assign w_pop   = valid_o & ready_i;

    idu_iq_ptr #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush_i),
        .push_i   (w_push),
        .pop_i    (w_pop),
        .wr_idx_o (w_wr_idx),
        .rd_idx_o (w_rd_idx),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .count_o  (count_o)
    );

    // Storage is not reset; stale contents are masked by valid_o below.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[w_wr_idx]     <= inst_i;
            r_addr[w_wr_idx]     <= inst_addr_i;
            r_int_flag[w_wr_idx] <= int_flag_i;
        end
    end

    always_comb begin
        inst_o      = DW'(INST_NOP);
        inst_addr_o = '0;
        int_flag_o  = '0;
        if (valid_o) begin
            inst_o      = r_inst[w_rd_idx];
            inst_addr_o = r_addr[w_rd_idx];
            int_flag_o  = r_int_flag[w_rd_idx];
        end
    end

endmodule

// File: tb/tb_idu_inst_queue.sv
// Bench for idu_inst_queue: vector table with hand-derived flags/count plus an in-order data scoreboard.
module tb_idu_inst_queue;
    import idu_inst_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, hold_i, valid_i, ready_i;
    logic [31:0] inst_i, inst_addr_i;
    logic [7:0]  int_flag_i;
    logic        ready_o, valid_o;
    logic [31:0] inst_o, inst_addr_o;
    logic [7:0]  int_flag_o;
    logic [2:0]  count_o;

    idu_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .valid_i     (valid_i),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .int_flag_i  (int_flag_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .int_flag_o  (int_flag_o),
        .ready_i     (ready_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush, hold, valid, rdy;
        logic [31:0] inst, addr;
        logic [7:0]  intf;
        logic        e_rdy, e_vld;
        logic [2:0]  e_cnt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    iq_entry_t sb[$];
    vec_t vecs[$];

    function automatic vec_t v(input logic f, input logic h, input logic vl, input logic r,
                               input logic [31:0] addr, input logic er, input logic ev,
                               input logic [2:0] ec);
        vec_t t;
        t.flush = f; t.hold = h; t.valid = vl; t.rdy = r;
        t.addr  = addr;
        t.inst  = 32'hA000_0000 | addr;
        t.intf  = addr[9:2];
        t.e_rdy = er; t.e_vld = ev; t.e_cnt = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle, check outputs before the edge, then advance the reference queue.
    task automatic apply(input vec_t t);
        logic      m_vld;
        iq_entry_t e;
        @(negedge clk);
        flush_i = t.flush; hold_i = t.hold; valid_i = t.valid; ready_i = t.rdy;
        inst_i = t.inst; inst_addr_i = t.addr; int_flag_i = t.intf;
        #1;
        chk("ready_o", 32'(ready_o), 32'(t.e_rdy));
        chk("valid_o", 32'(valid_o), 32'(t.e_vld));
        chk("count_o", 32'(count_o), 32'(t.e_cnt));
        m_vld = (sb.size() > 0) && !t.hold && !t.flush;
        if (m_vld) begin
            chk("head_inst", inst_o, sb[0].inst);
            chk("head_addr", inst_addr_o, sb[0].addr);
            chk("head_intf", 32'(int_flag_o), 32'(sb[0].int_flag));
        end else begin
            chk("nop_inst", inst_o, 32'h0000_0013);
            chk("nop_addr", inst_addr_o, 32'h0);
            chk("nop_intf", 32'(int_flag_o), 32'h0);
        end
        if (t.flush) begin
            sb.delete();
        end else begin
            if (m_vld && t.rdy) void'(sb.pop_front());
            if (t.valid && (sb.size() + (m_vld && t.rdy ? 1 : 0)) < DEPTH) begin
                e.inst = t.inst; e.addr = t.addr; e.int_flag = t.intf;
                sb.push_back(e);
            end
        end
    endtask

    initial begin
        vec_t t;
        rst = 1'b1;
        flush_i = 0; hold_i = 0; valid_i = 0; ready_i = 0;
        inst_i = 0; inst_addr_i = 0; int_flag_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // idle after reset
        vecs.push_back(v(0,0,0,0,32'h00, 1,0,0));
        // fill with ready_i=0; fifth push refused
        vecs.push_back(v(0,0,1,0,32'h00, 1,0,0));
        vecs.push_back(v(0,0,1,0,32'h04, 1,1,1));
        vecs.push_back(v(0,0,1,0,32'h08, 1,1,2));
        vecs.push_back(v(0,0,1,0,32'h0C, 1,1,3));
        vecs.push_back(v(0,0,1,0,32'h10, 0,1,4));
        // drain from full while pushing 0x10, 0x14 (pointers wrap)
        vecs.push_back(v(0,0,1,1,32'h10, 0,1,4));
        vecs.push_back(v(0,0,1,1,32'h10, 1,1,3));
        vecs.push_back(v(0,0,1,1,32'h14, 1,1,3));
        vecs.push_back(v(0,0,0,1,32'h00, 1,1,3));
        vecs.push_back(v(0,0,0,1,32'h00, 1,1,2));
        vecs.push_back(v(0,0,0,1,32'h00, 1,1,1));
        vecs.push_back(v(0,0,0,1,32'h00, 1,0,0));
        // flush mid-stream with a concurrent push of 0x20
        vecs.push_back(v(0,0,1,0,32'h40, 1,0,0));
        vecs.push_back(v(0,0,1,0,32'h44, 1,1,1));
        vecs.push_back(v(0,0,1,0,32'h48, 1,1,2));
        vecs.push_back(v(1,0,1,1,32'h20, 1,0,3));
        vecs.push_back(v(0,0,0,1,32'h00, 1,0,0));
        // hold for three cycles, then release in order
        vecs.push_back(v(0,0,1,0,32'h50, 1,0,0));
        vecs.push_back(v(0,0,1,0,32'h54, 1,1,1));
        vecs.push_back(v(0,1,0,1,32'h00, 1,0,2));
        vecs.push_back(v(0,1,0,1,32'h00, 1,0,2));
        vecs.push_back(v(0,1,0,1,32'h00, 1,0,2));
        vecs.push_back(v(0,0,0,1,32'h00, 1,1,2));
        vecs.push_back(v(0,0,0,1,32'h00, 1,1,1));
        vecs.push_back(v(0,0,0,1,32'h00, 1,0,0));
        // interrupt-tagged instruction pushed into empty with ready_i=1
        t = v(0,0,1,1,32'h80, 1,0,0);
        t.inst = 32'h0010_0093; t.intf = 8'h01;
        vecs.push_back(t);
        vecs.push_back(v(0,0,0,1,32'h00, 1,1,1));
        vecs.push_back(v(0,0,0,1,32'h00, 1,0,0));

        foreach (vecs[i]) apply(vecs[i]);

        // asynchronous reset in the middle of a cycle drops queued entries at once
        apply(v(0,0,1,0,32'h60, 1,0,0));
        apply(v(0,0,1,0,32'h64, 1,1,1));
        @(negedge clk);
        valid_i = 0; ready_i = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(valid_o), 32'h0);
        chk("async_count", 32'(count_o), 32'h0);
        chk("async_ready", 32'(ready_o), 32'h1);
        chk("async_inst",  inst_o, 32'h0000_0013);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        apply(v(0,0,0,0,32'h00, 1,0,0));
        apply(v(0,0,1,0,32'h70, 1,0,0));
        apply(v(0,0,0,1,32'h00, 1,1,1));
        apply(v(0,0,0,1,32'h00, 1,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
